// File: rtl/cache_controller.sv
// cache_controller: single-port 4-way set-associative data cache controller.
// Hits complete in two cycles; misses refill a 4-word line over four memory
// beats through an MSHR, whose datapath is exported for debug and trace.
// Optional feature macro: CC_CRITICAL_WORD_FIRST_EN (refill starts at the
// requested word and wraps; default build refills words 0,1,2,3).
module cache_controller #(
    parameter int unsigned ADR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned WORD_OFFSET   = 2,
    parameter int unsigned DATAMEM_WIDTH = 128,
    parameter int unsigned INDEX_WIDTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_cpu2cc,
    input  logic [ADR_WIDTH-1:0]     adr_cpu2cc,
    input  logic [DATA_WIDTH-1:0]    dat_cpu2cc,
    input  logic                     rdwr_cpu2cc,
    output logic                     ack_cc2cpu,
    output logic [DATA_WIDTH-1:0]    dat_cc2cpu,
    output logic                     req_cc2mem,
    output logic [ADR_WIDTH-1:0]     adr_cc2mem,
    input  logic                     ack_mem2cc,
    input  logic [DATA_WIDTH-1:0]    dat_mem2cc,
    output logic [DATA_WIDTH-1:0]    dat_mem2mshr,
    output logic [WORD_OFFSET-1:0]   word_mem2mshr,
    output logic [DATAMEM_WIDTH-1:0] dat_cc2mshr
);

    localparam int TagWidth = ADR_WIDTH - INDEX_WIDTH - WORD_OFFSET - 2;
    localparam int NumSets  = 2 ** INDEX_WIDTH;
    localparam int NumWays  = 4;

    typedef enum logic [2:0] {StIdle, StCompare, StRefill, StRespond, StRelease} state_e;

    state_e state_q, state_d;

    // Latched request (byte offset bits are carried but never used)
    logic [ADR_WIDTH-1:0]  adr_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic                  rdwr_q;

    // Cache arrays
    logic [NumWays-1:0]       valid_q [NumSets];
    logic [TagWidth-1:0]      tag_q   [NumSets][NumWays];
    logic [DATAMEM_WIDTH-1:0] line_q  [NumSets][NumWays];
    logic [1:0]               age_q   [NumSets][NumWays];

    // MSHR and refill beat counter
    logic [DATAMEM_WIDTH-1:0] mshr_q;
    logic [WORD_OFFSET-1:0]   beat_q;
    logic [DATA_WIDTH-1:0]    dat_cc2cpu_q;

    logic [WORD_OFFSET-1:0]   word_sel;
    logic [INDEX_WIDTH-1:0]   set_sel;
    logic [TagWidth-1:0]      tag_sel;
    logic [NumWays-1:0]       hit_vec;
    logic                     hit;
    logic [1:0]               hit_way;
    logic [1:0]               victim_way;
    logic                     invalid_found;
    logic [1:0]               access_way;
    logic [1:0]               old_age;
    logic                     last_beat;
    logic                     update;
    logic [DATAMEM_WIDTH-1:0] fill_line;
    logic [DATAMEM_WIDTH-1:0] new_line;
    logic [DATA_WIDTH-1:0]    rd_word;
    logic                     unused_byte_bits;

    assign unused_byte_bits = ^adr_q[1:0];

    assign word_sel = adr_q[WORD_OFFSET+1:2];
    assign set_sel  = adr_q[INDEX_WIDTH+WORD_OFFSET+1:WORD_OFFSET+2];
    assign tag_sel  = adr_q[ADR_WIDTH-1:ADR_WIDTH-TagWidth];

`ifdef CC_CRITICAL_WORD_FIRST_EN
    assign word_mem2mshr = beat_q + word_sel;
`else
    assign word_mem2mshr = beat_q;
`endif

    // Tag compare across all valid ways of the addressed set
    always_comb begin
        hit_vec = '0;
        hit_way = 2'd0;
        for (int w = 0; w < NumWays; w++) begin
            hit_vec[w] = valid_q[set_sel][w] && (tag_q[set_sel][w] == tag_sel);
            if (hit_vec[w]) hit_way = w[1:0];
        end
        hit = |hit_vec;
    end

    // Victim: lowest invalid way, else the least recently used (age 3)
    always_comb begin
        victim_way    = 2'd0;
        invalid_found = 1'b0;
        for (int w = 0; w < NumWays; w++) begin
            if (!invalid_found && !valid_q[set_sel][w]) begin
                victim_way    = w[1:0];
                invalid_found = 1'b1;
            end
        end
        if (!invalid_found) begin
            for (int w = 0; w < NumWays; w++) begin
                if (age_q[set_sel][w] == 2'd3) victim_way = w[1:0];
            end
        end
    end

    assign last_beat  = (state_q == StRefill) && ack_mem2cc && (beat_q == '1);
    assign update     = ((state_q == StCompare) && hit) || last_beat;
    assign access_way = (state_q == StCompare) ? hit_way : victim_way;
    assign old_age    = age_q[set_sel][access_way];

    // Line datapath: current beat merged into MSHR, then CPU write merged on top
    always_comb begin
        fill_line = mshr_q;
        fill_line[int'(word_mem2mshr)*DATA_WIDTH +: DATA_WIDTH] = dat_mem2cc;
        new_line  = (state_q == StCompare) ? line_q[set_sel][hit_way] : fill_line;
        if (rdwr_q) new_line[int'(word_sel)*DATA_WIDTH +: DATA_WIDTH] = dat_q;
        rd_word   = new_line[int'(word_sel)*DATA_WIDTH +: DATA_WIDTH];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (req_cpu2cc) state_d = StCompare;
            StCompare: state_d = hit ? StRespond : StRefill;
            StRefill:  if (last_beat) state_d = StRespond;
            StRespond: state_d = StRelease;
            StRelease: if (!req_cpu2cc) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Capture the CPU request when leaving idle
    always_ff @(posedge clk) begin
        if (rst) begin
            adr_q  <= '0;
            dat_q  <= '0;
            rdwr_q <= 1'b0;
        end else if ((state_q == StIdle) && req_cpu2cc) begin
            adr_q  <= adr_cpu2cc;
            dat_q  <= dat_cpu2cc;
            rdwr_q <= rdwr_cpu2cc;
        end
    end

    // MSHR fill and beat counter; acks outside refill are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            mshr_q <= '0;
            beat_q <= '0;
        end else if ((state_q == StRefill) && ack_mem2cc) begin
            mshr_q <= fill_line;
            beat_q <= beat_q + 1'b1;
        end
    end

    // Read data register, loaded on every hit or install
    always_ff @(posedge clk) begin
        if (rst)         dat_cc2cpu_q <= '0;
        else if (update) dat_cc2cpu_q <= rd_word;
    end

    // Valid, tag and LRU age state
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NumSets; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < NumWays; w++) begin
                    tag_q[s][w] <= '0;
                    age_q[s][w] <= w[1:0];
                end
            end
        end else if (update) begin
            valid_q[set_sel][access_way] <= 1'b1;
            tag_q[set_sel][access_way]   <= tag_sel;
            for (int w = 0; w < NumWays; w++) begin
                if (w[1:0] == access_way) begin
                    age_q[set_sel][w] <= 2'd0;
                end else if (age_q[set_sel][w] < old_age) begin
                    age_q[set_sel][w] <= age_q[set_sel][w] + 2'd1;
                end
            end
        end
    end

    // Line data storage; contents only meaningful where valid is set
    always_ff @(posedge clk) begin
        if (!rst && update) line_q[set_sel][access_way] <= new_line;
    end

    assign ack_cc2cpu   = (state_q == StRespond);
    assign dat_cc2cpu   = dat_cc2cpu_q;
    assign req_cc2mem   = (state_q == StRefill);
    assign adr_cc2mem   = req_cc2mem ?
                          {adr_q[ADR_WIDTH-1:WORD_OFFSET+2], word_mem2mshr, 2'b00} : '0;
    assign dat_mem2mshr = dat_mem2cc;
    assign dat_cc2mshr  = mshr_q;

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed vector table, multi-cycle
// corner sequences and randomized traffic against a recency-list cache model.
module tb_cache_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_cpu2cc;
    logic [31:0]  adr_cpu2cc;
    logic [31:0]  dat_cpu2cc;
    logic         rdwr_cpu2cc;
    logic         ack_cc2cpu;
    logic [31:0]  dat_cc2cpu;
    logic         req_cc2mem;
    logic [31:0]  adr_cc2mem;
    logic         ack_mem2cc;
    logic [31:0]  dat_mem2cc;
    logic [31:0]  dat_mem2mshr;
    logic [1:0]   word_mem2mshr;
    logic [127:0] dat_cc2mshr;

    cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .req_cpu2cc   (req_cpu2cc),
        .adr_cpu2cc   (adr_cpu2cc),
        .dat_cpu2cc   (dat_cpu2cc),
        .rdwr_cpu2cc  (rdwr_cpu2cc),
        .ack_cc2cpu   (ack_cc2cpu),
        .dat_cc2cpu   (dat_cc2cpu),
        .req_cc2mem   (req_cc2mem),
        .adr_cc2mem   (adr_cc2mem),
        .ack_mem2cc   (ack_mem2cc),
        .dat_mem2cc   (dat_mem2cc),
        .dat_mem2mshr (dat_mem2mshr),
        .word_mem2mshr(word_mem2mshr),
        .dat_cc2mshr  (dat_cc2mshr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory responder controls and beat trace
    bit          mem_ones      = 1'b1;
    bit          mem_rand      = 1'b0;
    int          mem_gap       = 0;
    int          mem_max_beats = 4;
    bit          stray_ack     = 1'b0;
    int          beats_this    = 0;
    logic [1:0]  q_word [$];
    logic [31:0] q_adr  [$];
    logic [31:0] q_dmm  [$];
    logic [31:0] q_dmc  [$];

    // Reference model: per set a recency list of ways, MRU first
    bit          m_valid [16][4];
    logic [23:0] m_tag   [16][4];
    logic [31:0] m_data  [16][4][4];
    int          m_order [16][$];

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [31:0] wdata;
        bit          exp_hit;
        bit          chk_data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem_ones) return 32'hFFFF_FFFF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            m_order[s].delete();
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 1'b0;
                m_order[s].push_back(w);
            end
        end
    endtask

    task automatic model_access(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                                output bit hit, output logic [31:0] rd,
                                output logic [127:0] raw);
        int s, way, pos;
        s   = int'(a[7:4]);
        way = -1;
        raw = '0;
        for (int w = 0; w < 4; w++)
            if (m_valid[s][w] && m_tag[s][w] == a[31:8]) way = w;
        hit = (way >= 0);
        if (!hit) begin
            for (int w = 3; w >= 0; w--) if (!m_valid[s][w]) way = w;
            if (way < 0) way = m_order[s][3];
            m_valid[s][way] = 1'b1;
            m_tag[s][way]   = a[31:8];
            for (int k = 0; k < 4; k++) begin
                m_data[s][way][k] = mem_val({a[31:4], k[1:0], 2'b00});
                raw[k*32 +: 32]   = m_data[s][way][k];
            end
        end
        if (wr) m_data[s][way][a[3:2]] = wd;
        rd  = m_data[s][way][a[3:2]];
        pos = 0;
        for (int i = 0; i < m_order[s].size(); i++) if (m_order[s][i] == way) pos = i;
        m_order[s].delete(pos);
        m_order[s].push_front(way);
    endtask

    // Memory responder: drives beats at the falling edge while a refill is requested
    initial begin
        int  gap_cnt;
        bit  go;
        gap_cnt    = 0;
        ack_mem2cc = 1'b0;
        dat_mem2cc = '0;
        forever begin
            @(negedge clk);
            go = 1'b0;
            if (!req_cc2mem) begin
                beats_this = 0;
                gap_cnt    = 0;
            end
            if (stray_ack) begin
                go = 1'b1;
            end else if (req_cc2mem && beats_this < mem_max_beats) begin
                if (mem_rand) begin
                    go = ($urandom_range(0, 1) == 1);
                end else begin
                    go      = (gap_cnt == 0);
                    gap_cnt = (gap_cnt >= mem_gap) ? 0 : gap_cnt + 1;
                end
            end
            ack_mem2cc = go;
            if (go && !stray_ack)   dat_mem2cc = mem_val(adr_cc2mem);
            else if (go || req_cc2mem) dat_mem2cc = $urandom;
            else                    dat_mem2cc = '0;
            if (go && req_cc2mem) begin
                beats_this++;
                #1;
                q_word.push_back(word_mem2mshr);
                q_adr.push_back(adr_cc2mem);
                q_dmm.push_back(dat_mem2mshr);
                q_dmc.push_back(dat_mem2cc);
            end
        end
    end

    // One CPU transaction, checked against the model; called at posedge + 1
    task automatic run_txn(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                           input bit drop_early, input int hold, input string nm,
                           output bit hit_o, output logic [31:0] rd_o);
        bit           exp_hit, got;
        logic [31:0]  exp_rd;
        logic [127:0] exp_raw, mshr_at_ack;
        logic [1:0]   st, expw;
        int           cyc, first_req, last_req, ack_cyc, extra;
        model_access(a, wr, wd, exp_hit, exp_rd, exp_raw);
        q_word.delete(); q_adr.delete(); q_dmm.delete(); q_dmc.delete();
        req_cpu2cc  = 1'b1;
        adr_cpu2cc  = a;
        dat_cpu2cc  = wd;
        rdwr_cpu2cc = wr;
        cyc = 0; got = 1'b0; first_req = -1; last_req = -1; ack_cyc = -1;
        rd_o = '0; mshr_at_ack = '0;
        while (!got && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (drop_early && cyc == 1) req_cpu2cc = 1'b0;
            if (req_cc2mem) begin
                if (first_req < 0) first_req = cyc;
                last_req = cyc;
            end
            if (ack_cc2cpu) begin
                got         = 1'b1;
                ack_cyc     = cyc;
                rd_o        = dat_cc2cpu;
                mshr_at_ack = dat_cc2mshr;
            end
        end
        hit_o = got && (first_req < 0);
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no ack expected ack", nm);
        end else begin
            chk({nm, " hit"}, 128'(hit_o), 128'(exp_hit));
            if (exp_hit) begin
                chk({nm, " hit_latency"}, ack_cyc, 2);
            end else begin
                chk({nm, " req_rise"}, first_req, 2);
                chk({nm, " ack_after_req_fall"}, ack_cyc, last_req + 1);
                chk({nm, " beats"}, q_word.size(), 4);
`ifdef CC_CRITICAL_WORD_FIRST_EN
                st = a[3:2];
`else
                st = 2'd0;
`endif
                for (int k = 0; k < 4 && k < q_word.size(); k++) begin
                    expw = st + k[1:0];
                    chk($sformatf("%s word%0d", nm, k), q_word[k], expw);
                    chk($sformatf("%s adr%0d", nm, k), q_adr[k], {a[31:4], expw, 2'b00});
                    chk($sformatf("%s mshr_dat%0d", nm, k), q_dmm[k], q_dmc[k]);
                end
                chk({nm, " mshr_line"}, mshr_at_ack, exp_raw);
            end
            if (!wr) chk({nm, " rdata"}, rd_o, exp_rd);
        end
        extra = 0;
        repeat (hold) begin
            @(posedge clk); #1;
            if (ack_cc2cpu || req_cc2mem) extra++;
        end
        req_cpu2cc = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (ack_cc2cpu || req_cc2mem) extra++;
        end
        chk({nm, " no_retrigger"}, extra, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          h;
        logic [31:0] r, a;
        int          extra, n;

        rst = 1'b1; req_cpu2cc = 1'b0; adr_cpu2cc = '0; dat_cpu2cc = '0; rdwr_cpu2cc = 1'b0;
        model_reset();
        vecs[0]  = '{32'hFF07BD08, 1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFFFFFF};
        vecs[1]  = '{32'hA5552D0C, 1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFFFFFF};
        vecs[2]  = '{32'hD500AD00, 1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFFFFFF};
        vecs[3]  = '{32'hFFFFFD08, 1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFFFFFF};
        vecs[4]  = '{32'hFF07BD00, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFFFFFF};
        vecs[5]  = '{32'hFFFFFD08, 1'b1, 32'h55455552, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{32'hA5552D08, 1'b1, 32'hAA8AAAA4, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{32'hA5552D08, 1'b0, 32'h0,        1'b1, 1'b1, 32'hAA8AAAA4};
        vecs[8]  = '{32'hAFD52D08, 1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFFFFFF};
        vecs[9]  = '{32'hD500AD00, 1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFFFFFF};
        vecs[10] = '{32'hFFFFFD08, 1'b0, 32'h0,        1'b1, 1'b1, 32'h55455552};
        vecs[11] = '{32'hFF07BD04, 1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFFFFFF};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst ack", ack_cc2cpu, 0);
        chk("rst req_mem", req_cc2mem, 0);
        chk("rst adr_mem", adr_cc2mem, 0);
        chk("rst dat_cpu", dat_cc2cpu, 0);
        chk("rst dat_mem2mshr", dat_mem2mshr, 0);
        chk("rst word", word_mem2mshr, 0);
        chk("rst mshr", dat_cc2mshr, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed set-0 scenario: fill, hits, writes, LRU victim
        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].addr, vecs[i].wr, vecs[i].wdata, 1'b0, 0,
                    $sformatf("vec%0d", i), h, r);
            chk($sformatf("vec%0d table_hit", i), 128'(h), 128'(vecs[i].exp_hit));
            if (vecs[i].chk_data) chk($sformatf("vec%0d table_data", i), r, vecs[i].exp_data);
        end

        // Gapped acks: one beat every second cycle
        mem_gap = 1;
        run_txn(32'h0000_0238, 1'b0, 32'h0, 1'b0, 0, "gapped", h, r);
        chk("gapped mshr_ones", dat_cc2mshr, {128{1'b1}});
        mem_gap = 0;

        // Acks while idle must not move the beat counter
        stray_ack = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        stray_ack = 1'b0;
        @(posedge clk); #1;
        run_txn(32'h0000_0340, 1'b0, 32'h0, 1'b0, 0, "after_stray", h, r);

        // Request dropped before ack, and a request held long after ack
        mem_ones = 1'b0;
        run_txn(32'h0000_0768, 1'b0, 32'h0, 1'b1, 0, "drop_miss", h, r);
        run_txn(32'h0000_0764, 1'b1, 32'h1357_9BDF, 1'b1, 0, "drop_hit_wr", h, r);
        run_txn(32'h0000_0764, 1'b0, 32'h0, 1'b0, 5, "held_hit", h, r);
        run_txn(32'h0000_0E7C, 1'b1, 32'hCAFE_F00D, 1'b0, 0, "wr_miss", h, r);
        run_txn(32'h0000_0E7C, 1'b0, 32'h0, 1'b0, 0, "wr_miss_readback", h, r);

        // Reset asserted after the second beat of a refill
        mem_max_beats = 2;
        req_cpu2cc = 1'b1; adr_cpu2cc = 32'h0000_0854; rdwr_cpu2cc = 1'b0;
        n = 0;
        while (beats_this < 2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("midrst two_beats", beats_this, 2);
        rst = 1'b1;
        req_cpu2cc = 1'b0;
        @(posedge clk); #1;
        chk("midrst req_mem", req_cc2mem, 0);
        chk("midrst ack", ack_cc2cpu, 0);
        chk("midrst mshr", dat_cc2mshr, 0);
        chk("midrst word", word_mem2mshr, 0);
        chk("midrst adr_mem", adr_cc2mem, 0);
        rst = 1'b0;
        model_reset();
        mem_max_beats = 4;
        extra = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack_cc2cpu || req_cc2mem) extra++;
        end
        chk("midrst quiet", extra, 0);
        run_txn(32'h0000_0854, 1'b0, 32'h0, 1'b0, 0, "midrst reread", h, r);
        chk("midrst reread_miss", 128'(h), 0);

        // Randomized traffic with random ack gaps
        mem_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            a = {24'h00A000 + 24'($urandom_range(0, 5)), 4'($urandom_range(1, 2)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            run_txn(a, ($urandom_range(0, 2) == 0), $urandom, ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 2), $sformatf("rnd%0d", i), h, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
